hazard_forward_unit: RTL and testbench

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

---
 rtl/hazard_forward_unit_pkg.sv | 17 +
 rtl/hazard_forward_unit_fwd_match.sv | 36 +++
 rtl/hazard_forward_unit.sv | 141 ++++++++++++++
 tb/tb_hazard_forward_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_forward_unit_pkg.sv
// rtl/hazard_forward_unit_pkg.sv - shared defaults, FSM encodings and select codes for the hazard/forward unit
package hazard_forward_unit_pkg;

    localparam int DEF_REG_AW    = 5;
    localparam int DEF_NUM_SRC   = 2;
    localparam int DEF_FWD_DEPTH = 3;
    localparam int DEF_LOAD_LAT  = 1;

    // fwd_sel code meaning "read the register file"; code k+1 means shadow entry k
    localparam int FWD_SEL_RF = 0;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } hfu_state_t;

endpackage

// File: rtl/hazard_forward_unit_fwd_match.sv
// rtl/hazard_forward_unit_fwd_match.sv - per-operand youngest-match forward select and load-use block
module fwd_match
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_AW    = DEF_REG_AW,
    parameter int FWD_DEPTH = DEF_FWD_DEPTH,
    parameter int LOAD_LAT  = DEF_LOAD_LAT,
    parameter int SELW      = $clog2(DEF_FWD_DEPTH + 1)
) (
    input  logic [REG_AW-1:0]           src,
    input  logic                        used,
    input  logic [FWD_DEPTH-1:0]        ent_valid,
    input  logic [FWD_DEPTH-1:0]        ent_wr,
    input  logic [FWD_DEPTH-1:0]        ent_load,
    input  logic [FWD_DEPTH*REG_AW-1:0] ent_dst,
    output logic [SELW-1:0]             sel,
    output logic                        blocked,
    output logic [SELW-1:0]             wait_cycles
);

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        sel         = SELW'(FWD_SEL_RF);
        blocked     = 1'b0;
        wait_cycles = '0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (ent_valid[k] && ent_wr[k] && used && (src != '0) &&
                (ent_dst[k*REG_AW +: REG_AW] == src)) begin
                sel         = SELW'(k + 1);
                blocked     = ent_load[k] && (k < LOAD_LAT);
                wait_cycles = (ent_load[k] && (k < LOAD_LAT)) ? SELW'(LOAD_LAT - k) : '0;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - ID-stage hazard detection, operand forwarding select and load-use stall control
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_AW    = DEF_REG_AW,
    parameter int NUM_SRC   = DEF_NUM_SRC,
    parameter int FWD_DEPTH = DEF_FWD_DEPTH,
    parameter int LOAD_LAT  = DEF_LOAD_LAT
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]                    id_src_reg,
    input  logic [NUM_SRC-1:0]                           id_src_used,
    input  logic [REG_AW-1:0]                            id_dst_reg,
    input  logic                                         id_reg_write,
    input  logic                                         id_is_load,
    input  logic                                         flush,
    output logic                                         stall,
    output logic                                         issue,
    output logic [NUM_SRC*$clog2(FWD_DEPTH+1)-1:0]       fwd_sel,
    output logic [15:0]                                  stall_cnt
);

    localparam int SELW = $clog2(FWD_DEPTH + 1);

    logic [FWD_DEPTH-1:0]        ent_valid;
    logic [FWD_DEPTH-1:0]        ent_wr;
    logic [FWD_DEPTH-1:0]        ent_load;
    logic [FWD_DEPTH*REG_AW-1:0] ent_dst;

    logic [NUM_SRC-1:0]          op_blocked;
    logic [NUM_SRC*SELW-1:0]     op_wait;
    logic [SELW-1:0]             max_wait;
    logic [SELW-1:0]             wait_cnt;

    hfu_state_t                  state;
    hfu_state_t                  state_nxt;
    logic                        in_wait;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_op
        fwd_match #(
            .REG_AW    (REG_AW),
            .FWD_DEPTH (FWD_DEPTH),
            .LOAD_LAT  (LOAD_LAT),
            .SELW      (SELW)
        ) u_fwd_match (
            .src         (id_src_reg[i*REG_AW +: REG_AW]),
            .used        (id_src_used[i]),
            .ent_valid   (ent_valid),
            .ent_wr      (ent_wr),
            .ent_load    (ent_load),
            .ent_dst     (ent_dst),
            .sel         (fwd_sel[i*SELW +: SELW]),
            .blocked     (op_blocked[i]),
            .wait_cycles (op_wait[i*SELW +: SELW])
        );
    end

    assign stall = id_valid && !flush && (|op_blocked);
    assign issue = id_valid && !stall && !flush;

    // Longest remaining load latency across all blocked operands seeds the wait counter.
    always_comb begin
        max_wait = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (op_wait[i*SELW +: SELW] > max_wait) begin
                max_wait = op_wait[i*SELW +: SELW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_valid <= '0;
            ent_wr    <= '0;
            ent_load  <= '0;
            ent_dst   <= '0;
        end else begin
            ent_valid[0]          <= issue;
            ent_wr[0]             <= id_reg_write;
            ent_load[0]           <= id_is_load;
            ent_dst[0 +: REG_AW]  <= id_dst_reg;
            for (int k = 1; k < FWD_DEPTH; k++) begin
                ent_valid[k]               <= ent_valid[k-1] && !flush;
                ent_wr[k]                  <= ent_wr[k-1];
                ent_load[k]                <= ent_load[k-1];
                ent_dst[k*REG_AW +: REG_AW] <= ent_dst[(k-1)*REG_AW +: REG_AW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:  if (stall && !flush) state_nxt = ST_WAIT;
            ST_WAIT: if (flush || !stall) state_nxt = ST_RUN;
            default: state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        in_wait = (state == ST_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (flush || (in_wait && !stall)) begin
            wait_cnt <= '0;
        end else if (!in_wait && stall) begin
            wait_cnt <= max_wait;
        end else if (in_wait && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    // A stall still held once the latency countdown is exhausted means the match logic and FSM disagree.
    always_ff @(posedge clk) begin
        if (rst_n && in_wait && stall) begin
            assert (wait_cnt != '0);
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - table/scoreboard bench for hazard_forward_unit (default and swept parameters)
module tb_hazard_forward_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default parameters
    logic        a_valid, a_wr, a_ld, a_flush;
    logic [9:0]  a_src;
    logic [1:0]  a_used;
    logic [4:0]  a_dst;
    logic        a_stall, a_issue;
    logic [3:0]  a_sel;
    logic [15:0] a_cnt;

    // DUT B: NUM_SRC=3, FWD_DEPTH=4, LOAD_LAT=2
    logic        b_valid, b_wr, b_ld, b_flush;
    logic [14:0] b_src;
    logic [2:0]  b_used;
    logic [4:0]  b_dst;
    logic        b_stall, b_issue;
    logic [8:0]  b_sel;
    logic [15:0] b_cnt;

    hazard_forward_unit u_dut_a (
        .clk(clk), .rst_n(rst_n), .id_valid(a_valid), .id_src_reg(a_src),
        .id_src_used(a_used), .id_dst_reg(a_dst), .id_reg_write(a_wr),
        .id_is_load(a_ld), .flush(a_flush), .stall(a_stall), .issue(a_issue),
        .fwd_sel(a_sel), .stall_cnt(a_cnt)
    );

    hazard_forward_unit #(.REG_AW(5), .NUM_SRC(3), .FWD_DEPTH(4), .LOAD_LAT(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .id_valid(b_valid), .id_src_reg(b_src),
        .id_src_used(b_used), .id_dst_reg(b_dst), .id_reg_write(b_wr),
        .id_is_load(b_ld), .flush(b_flush), .stall(b_stall), .issue(b_issue),
        .fwd_sel(b_sel), .stall_cnt(b_cnt)
    );

    typedef struct {
        logic       v;
        logic [4:0] s0, s1;
        logic [1:0] used;
        logic [4:0] dst;
        logic       wr, ld, fl;
        logic       e_stall, e_issue;
        logic [1:0] e_sel0, e_sel1;
        logic [15:0] e_cnt;
    } vec_t;

    typedef struct {
        string       tag;
        logic        stall, issue;
        logic [8:0]  sel;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_a(input string tag, input logic st, input logic is, input logic [8:0] sel, input logic [15:0] cnt);
        exp_t e;
        e.tag = tag; e.stall = st; e.issue = is; e.sel = sel; e.cnt = cnt;
        sb_a.push_back(e);
    endtask

    task automatic push_b(input string tag, input logic st, input logic is, input logic [8:0] sel, input logic [15:0] cnt);
        exp_t e;
        e.tag = tag; e.stall = st; e.issue = is; e.sel = sel; e.cnt = cnt;
        sb_b.push_back(e);
    endtask

    task automatic compare_a();
        exp_t e;
        if (sb_a.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL sb_a_empty: got 0 entries expected 1");
        end else begin
            e = sb_a.pop_front();
            check({e.tag, ".stall"}, 32'(a_stall), 32'(e.stall));
            check({e.tag, ".issue"}, 32'(a_issue), 32'(e.issue));
            check({e.tag, ".fwd_sel"}, 32'(a_sel), 32'(e.sel));
            check({e.tag, ".stall_cnt"}, 32'(a_cnt), 32'(e.cnt));
        end
    endtask

    task automatic compare_b();
        exp_t e;
        if (sb_b.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL sb_b_empty: got 0 entries expected 1");
        end else begin
            e = sb_b.pop_front();
            check({e.tag, ".stall"}, 32'(b_stall), 32'(e.stall));
            check({e.tag, ".issue"}, 32'(b_issue), 32'(e.issue));
            check({e.tag, ".fwd_sel"}, 32'(b_sel), 32'(e.sel));
            check({e.tag, ".stall_cnt"}, 32'(b_cnt), 32'(e.cnt));
        end
    endtask

    task automatic drive_a(input logic v, input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                           input logic [4:0] dst, input logic wr, input logic ld, input logic fl);
        a_valid = v; a_src = {s1, s0}; a_used = used; a_dst = dst; a_wr = wr; a_ld = ld; a_flush = fl;
    endtask

    task automatic drive_b(input logic v, input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                           input logic [2:0] used, input logic [4:0] dst, input logic wr, input logic ld, input logic fl);
        b_valid = v; b_src = {s2, s1, s0}; b_used = used; b_dst = dst; b_wr = wr; b_ld = ld; b_flush = fl;
    endtask

    task automatic step_b(input string tag, input logic v, input logic [4:0] s0, input logic [4:0] s2,
                          input logic [2:0] used, input logic [4:0] dst, input logic wr, input logic ld,
                          input logic fl, input logic st, input logic is, input logic [8:0] sel, input logic [15:0] cnt);
        @(posedge clk); #1;
        drive_b(v, s0, 5'd0, s2, used, dst, wr, ld, fl);
        push_b(tag, st, is, sel, cnt);
        @(negedge clk);
        compare_b();
    endtask

    vec_t vecs[17];

    initial begin
        //          v  s0 s1  used   dst  wr ld fl  stall issue sel0 sel1 cnt
        vecs[0]  = '{1, 1, 2, 2'b11, 3,   1, 0, 0,  0, 1, 0, 0, 0};
        vecs[1]  = '{1, 3, 0, 2'b01, 6,   1, 0, 0,  0, 1, 1, 0, 0};
        vecs[2]  = '{1, 1, 3, 2'b11, 0,   0, 0, 0,  0, 1, 0, 2, 0};
        vecs[3]  = '{1, 1, 0, 2'b01, 5,   1, 1, 0,  0, 1, 0, 0, 0};
        vecs[4]  = '{1, 0, 5, 2'b10, 7,   1, 0, 0,  1, 0, 0, 1, 0};
        vecs[5]  = '{1, 0, 5, 2'b10, 7,   1, 0, 0,  0, 1, 0, 2, 1};
        vecs[6]  = '{1, 0, 0, 2'b00, 4,   1, 0, 0,  0, 1, 0, 0, 1};
        vecs[7]  = '{1, 0, 0, 2'b00, 4,   1, 0, 0,  0, 1, 0, 0, 1};
        vecs[8]  = '{1, 4, 4, 2'b11, 0,   1, 0, 0,  0, 1, 1, 1, 1};
        vecs[9]  = '{1, 0, 0, 2'b01, 9,   0, 0, 0,  0, 1, 0, 0, 1};
        vecs[10] = '{1, 0, 0, 2'b00, 8,   1, 1, 0,  0, 1, 0, 0, 1};
        vecs[11] = '{1, 8, 0, 2'b01, 10,  1, 0, 1,  0, 0, 1, 0, 1};
        vecs[12] = '{1, 8, 0, 2'b01, 10,  1, 0, 0,  0, 1, 0, 0, 1};
        vecs[13] = '{0, 10, 0, 2'b01, 0,  0, 0, 0,  0, 0, 1, 0, 1};
        vecs[14] = '{1, 10, 0, 2'b01, 0,  0, 0, 0,  0, 1, 2, 0, 1};
        vecs[15] = '{1, 0, 0, 2'b00, 0,   1, 1, 0,  0, 1, 0, 0, 1};
        vecs[16] = '{1, 0, 0, 2'b01, 0,   0, 0, 0,  0, 1, 0, 0, 1};

        // Reset: hazards cannot exist, outputs idle even with an instruction present
        drive_a(1, 3, 0, 2'b01, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
        #12;
        push_a("reset_a", 0, 1, 9'd0, 16'd0);
        compare_a();
        push_b("reset_b", 0, 0, 9'd0, 16'd0);
        compare_b();
        a_valid = 1'b0;
        #1 rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #1;
            drive_a(vecs[i].v, vecs[i].s0, vecs[i].s1, vecs[i].used, vecs[i].dst,
                    vecs[i].wr, vecs[i].ld, vecs[i].fl);
            push_a($sformatf("a%0d", i), vecs[i].e_stall, vecs[i].e_issue,
                   9'({vecs[i].e_sel1, vecs[i].e_sel0}), vecs[i].e_cnt);
            @(negedge clk);
            compare_a();
        end

        // Reset asserted in the middle of a load-use stall
        @(posedge clk); #1;
        drive_a(1, 0, 0, 2'b00, 5, 1, 1, 0);
        push_a("rst_load", 0, 1, 9'd0, 16'd1);
        @(negedge clk);
        compare_a();
        @(posedge clk); #1;
        drive_a(1, 5, 0, 2'b01, 0, 0, 0, 0);
        push_a("rst_use", 1, 0, 9'd1, 16'd1);
        @(negedge clk);
        compare_a();
        #1 rst_n = 1'b0;
        #1;
        push_a("rst_mid", 0, 1, 9'd0, 16'd0);
        compare_a();
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        push_a("rst_after", 0, 1, 9'd0, 16'd0);
        @(negedge clk);
        compare_a();
        a_valid = 1'b0;

        // Swept parameters: two-cycle load-use, then flush during a stall
        step_b("b0", 1, 0, 0, 3'b000, 5, 1, 1, 0,  0, 1, 9'd0,   16'd0);
        step_b("b1", 1, 0, 5, 3'b100, 0, 0, 0, 0,  1, 0, 9'd64,  16'd0);
        step_b("b2", 1, 0, 5, 3'b100, 0, 0, 0, 0,  1, 0, 9'd128, 16'd1);
        step_b("b3", 1, 0, 5, 3'b100, 0, 0, 0, 0,  0, 1, 9'd192, 16'd2);
        step_b("b4", 1, 0, 0, 3'b000, 9, 1, 1, 0,  0, 1, 9'd0,   16'd2);
        step_b("b5", 1, 9, 0, 3'b001, 0, 0, 0, 0,  1, 0, 9'd1,   16'd2);
        step_b("b6", 1, 9, 0, 3'b001, 0, 0, 0, 1,  0, 0, 9'd2,   16'd3);
        step_b("b7", 1, 9, 0, 3'b001, 0, 0, 0, 0,  0, 1, 9'd0,   16'd3);
        b_valid = 1'b0;

        if (sb_a.size() != 0 || sb_b.size() != 0) begin
            n_vec++; n_miss++;
            $display("FAIL sb_drain: got %0d leftover expected 0", sb_a.size() + sb_b.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
